// File: rtl/pio_pkg.sv
// Shared PIO constants, OSR action bundle and count decoding.
// Count fields use 0 to encode a full 32-bit word.
package pio_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  typedef struct packed {
    logic pop;
    logic zero;
    logic fire;
    logic stall;
  } osr_act_t;

  function automatic logic [5:0] decode_bits(
    input logic [4:0] v
  );
    decode_bits = (v == 5'd0) ? 6'd32 : {1'b0, v};
  endfunction

endpackage

// File: rtl/osr_extract.sv
// Combinational OSR bit extraction and shift for OUT.
// n ranges 1..32; n == 32 is handled explicitly.
module osr_extract
  import pio_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] osr,
  input  logic [5:0]            n,
  input  logic                  dir,
  output logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] next_osr
);

  logic            full;
  logic [5:0]      rsh;
  logic [DATA_WIDTH-1:0] mask;

  assign full = n[5];
  assign rsh  = 6'(DATA_WIDTH) - n;
  assign mask = ~({DATA_WIDTH{1'b1}} << n[4:0]);

  always_comb begin
    data     = osr;
    next_osr = '0;
    unique case (dir)
      SHIFT_RIGHT: begin
        if (!full) begin
          data     = osr & mask;
          next_osr = osr >> n[4:0];
        end
      end
      SHIFT_LEFT: begin
        if (!full) begin
          data     = osr >> rsh[4:0];
          next_osr = osr << n[4:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/output_shift_register.sv
// PIO output shift register: OUT/PULL execution with autopull refill.
// Pin writes appear one cycle after an OUT is accepted.
module output_shift_register #(
  parameter int DATA_WIDTH = pio_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_shiftDir,
  input  logic                  cfg_autopull,
  input  logic [4:0]            cfg_pullThresh,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_valid,
  output logic                  fifo_ready,
  input  logic                  op_out,
  input  logic [4:0]            op_count,
  input  logic                  op_pull,
  input  logic                  op_block,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_enable,
  output logic                  stall,
  output logic [5:0]            osr_count
);

  import pio_pkg::*;

  logic [DATA_WIDTH-1:0] osr_q, osr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] ext_data, ext_next;
  logic [5:0]            cnt_q, cnt_d;
  logic [5:0]            n, thresh;
  logic [6:0]            cnt_sum;
  logic                  wen_q, wen_d;
  logic                  ap_need;
  osr_act_t              act;

  assign n       = decode_bits(op_count);
  assign thresh  = decode_bits(cfg_pullThresh);
  assign ap_need = cfg_autopull && (cnt_q >= thresh);
  assign cnt_sum = {1'b0, cnt_q} + {1'b0, n};

  osr_extract u_ext (
    .osr      (osr_q),
    .n        (n),
    .dir      (cfg_shiftDir),
    .data     (ext_data),
    .next_osr (ext_next)
  );

  // A PULL and an autopull share one pop; PULL wins over OUT.
  always_comb begin
    act = '0;
    if (reset_n) begin
      act.pop   = fifo_valid && (op_pull || ap_need);
      act.zero  = op_pull && !fifo_valid && !op_block;
      act.fire  = op_out && !op_pull && !ap_need;
      act.stall = op_pull ? (!fifo_valid && op_block)
                          : (op_out && ap_need);
    end
  end

  always_comb begin
    osr_d   = osr_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    unique case (1'b1)
      act.pop: begin
        osr_d = fifo_data;
        cnt_d = '0;
      end
      act.zero: begin
        osr_d = '0;
        cnt_d = '0;
      end
      act.fire: begin
        osr_d   = ext_next;
        cnt_d   = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];
        wdata_d = ext_data;
        wen_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      osr_q   <= '0;
      cnt_q   <= 6'd32;
      wdata_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      osr_q   <= osr_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
    end
  end

  assign fifo_ready   = act.pop;
  assign stall        = act.stall;
  assign write_data   = wdata_q;
  assign write_enable = wen_q;
  assign osr_count    = cnt_q;

endmodule

// File: tb/tb_output_shift_register.sv
// Self-checking bench for output_shift_register.
// Directed vectors plus random ops against an arithmetic OSR model.
module tb_output_shift_register;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_shiftDir = 1'b0;
  logic        cfg_autopull = 1'b0;
  logic [4:0]  cfg_pullThresh = 5'd0;
  logic [31:0] fifo_data = 32'd0;
  logic        fifo_valid = 1'b0;
  logic        fifo_ready;
  logic        op_out = 1'b0;
  logic [4:0]  op_count = 5'd0;
  logic        op_pull = 1'b0;
  logic        op_block = 1'b0;
  logic [31:0] write_data;
  logic        write_enable;
  logic        stall;
  logic [5:0]  osr_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_osr;
  int          m_cnt;
  logic [31:0] m_wd;
  logic        m_we;
  logic        obs_stall = 1'b0;
  logic        obs_ready = 1'b0;

  always #5 clk = ~clk;

  output_shift_register dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_shiftDir   (cfg_shiftDir),
    .cfg_autopull   (cfg_autopull),
    .cfg_pullThresh (cfg_pullThresh),
    .fifo_data      (fifo_data),
    .fifo_valid     (fifo_valid),
    .fifo_ready     (fifo_ready),
    .op_out         (op_out),
    .op_count       (op_count),
    .op_pull        (op_pull),
    .op_block       (op_block),
    .write_data     (write_data),
    .write_enable   (write_enable),
    .stall          (stall),
    .osr_count      (osr_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_osr = 64'd0;
    m_cnt = 32;
    m_wd  = 32'd0;
    m_we  = 1'b0;
  endtask

  task automatic cyc(input logic o, input logic p, input logic b,
                     input logic [4:0] c, input logic fv,
                     input logic [31:0] fd);
    int          n, th;
    logic        need, e_ready, e_stall;
    logic [63:0] t, data, pw;
    @(negedge clk);
    op_out = o; op_pull = p; op_block = b; op_count = c;
    fifo_valid = fv; fifo_data = fd;
    #1;
    n  = (c == 5'd0) ? 32 : int'(c);
    th = (cfg_pullThresh == 5'd0) ? 32 : int'(cfg_pullThresh);
    need    = cfg_autopull && (m_cnt >= th);
    e_ready = fv && (p || need);
    e_stall = p ? (!fv && b) : (o && need);
    chk("stall", stall, e_stall);
    chk("fifo_ready", fifo_ready, e_ready);
    obs_stall = stall;
    obs_ready = fifo_ready;
    m_we = 1'b0;
    pw = 64'd1 << n;
    if (e_ready) begin
      m_osr = {32'd0, fd};
      m_cnt = 0;
    end else if (p && !b) begin
      m_osr = 64'd0;
      m_cnt = 0;
    end else if (o && !p && !need) begin
      if (cfg_shiftDir) begin
        data  = m_osr % pw;
        m_osr = m_osr / pw;
      end else begin
        t     = m_osr * pw;
        data  = t / 64'h1_0000_0000;
        m_osr = t % 64'h1_0000_0000;
      end
      m_wd  = data[31:0];
      m_we  = 1'b1;
      m_cnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
    end
    @(posedge clk);
    #1;
    chk("write_enable", write_enable, m_we);
    chk("write_data", write_data, m_wd);
    chk("osr_count", osr_count, 64'(m_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic ro, rp, rb, rfv;
    logic [4:0] rc;
    int r;
    m_reset();
    op_pull = 1'b1; fifo_valid = 1'b1; fifo_data = 32'h1;
    #2;
    chk("rst_ready", fifo_ready, 0);
    chk("rst_stall", stall, 0);
    #20;
    op_pull = 1'b0; fifo_valid = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("rel_we", write_enable, 0);
    chk("rel_ready", fifo_ready, 0);
    chk("rel_stall", stall, 0);
    chk("rel_cnt", osr_count, 32);
    chk("rel_wd", write_data, 0);

    cfg_shiftDir = 1'b1;
    cyc(0, 1, 1, 0, 1, 32'hA5A500FF);
    cyc(1, 0, 0, 8, 0, 0);
    chk("r_wd1", write_data, 32'h000000FF);
    chk("r_cnt1", osr_count, 8);
    cyc(1, 0, 0, 8, 0, 0);
    chk("r_wd2", write_data, 32'h00000000);
    chk("r_we2", write_enable, 1);
    chk("r_cnt2", osr_count, 16);
    cyc(0, 0, 0, 0, 0, 0);
    chk("r_we_drop", write_enable, 0);

    cfg_shiftDir = 1'b0;
    cyc(0, 1, 1, 0, 1, 32'hF0000001);
    cyc(1, 0, 0, 4, 0, 0);
    chk("l_wd1", write_data, 32'h0000000F);
    cyc(1, 0, 0, 28, 0, 0);
    chk("l_wd2", write_data, 32'h00000001);
    chk("l_cnt2", osr_count, 32);

    cfg_shiftDir = 1'b1; cfg_autopull = 1'b1; cfg_pullThresh = 5'd16;
    cyc(0, 0, 0, 0, 1, 32'h12345678);
    chk("ap_pop1", obs_ready, 1);
    cyc(1, 0, 0, 16, 0, 0);
    chk("ap_wd1", write_data, 32'h00005678);
    cyc(1, 0, 0, 16, 1, 32'hCAFEBABE);
    chk("ap_stall", obs_stall, 1);
    chk("ap_pop2", obs_ready, 1);
    chk("ap_nowe", write_enable, 0);
    cyc(1, 0, 0, 16, 0, 0);
    chk("ap_run", obs_stall, 0);
    chk("ap_wd2", write_data, 32'h0000BABE);
    cfg_autopull = 1'b0;

    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 0, 0, 0);
      chk("bp_stall", obs_stall, 1);
    end
    cyc(0, 1, 1, 0, 1, 32'hDEADBEEF);
    chk("bp_ready", obs_ready, 1);
    chk("bp_nostall", obs_stall, 0);
    chk("bp_cnt", osr_count, 0);

    cyc(0, 1, 0, 0, 0, 0);
    chk("nb_stall", obs_stall, 0);
    chk("nb_cnt", osr_count, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("nb_zero", write_data, 0);

    cyc(0, 1, 1, 0, 1, 32'h00000055);
    cyc(1, 0, 0, 8, 0, 0);
    op_pull = 1'b1; fifo_valid = 1'b1; reset_n = 1'b0;
    #1;
    chk("mr_we", write_enable, 0);
    chk("mr_cnt", osr_count, 32);
    chk("mr_wd", write_data, 0);
    chk("mr_ready", fifo_ready, 0);
    chk("mr_stall", stall, 0);
    m_reset();
    @(negedge clk);
    op_pull = 1'b0; fifo_valid = 1'b0; reset_n = 1'b1;

    ro = 0; rp = 0; rb = 0; rc = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0 && !obs_stall) begin
        cfg_shiftDir   = 1'($urandom_range(0, 1));
        cfg_autopull   = 1'($urandom_range(0, 1));
        cfg_pullThresh = 5'($urandom_range(0, 31));
      end
      if (!obs_stall) begin
        r  = $urandom_range(0, 9);
        ro = (r < 7);
        rp = (r >= 6);
        rb = 1'($urandom_range(0, 1));
        rc = 5'($urandom_range(0, 31));
      end
      rfv = ($urandom_range(0, 3) != 0);
      cyc(ro, rp, rb, rc, rfv, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_shift_register.md
OUTPUT_SHIFT_REGISTER -- requirements
Module: output_shift_register

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 32, OSR and pin-write word width.
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cfg_shiftDir  in  1  0 = shift left (MSB first), 1 = shift right (LSB first).
REQ-005 SHALL have port: cfg_autopull  in  1  enable automatic refill.
REQ-006 SHALL have port: cfg_pullThresh  in  5  autopull threshold in bits; 0 encodes 32.
REQ-007 SHALL have ports: fifo_data  in  32; fifo_valid  in  1; fifo_ready  out  1. These form the TX FIFO pop handshake.
REQ-008 SHALL have ports: op_out  in  1; op_count  in  5. op_out requests an OUT of op_count bits; op_count 0 encodes 32.
REQ-009 SHALL have ports: op_pull  in  1; op_block  in  1. op_pull requests an explicit PULL; op_block selects blocking behaviour.
REQ-010 SHALL have ports: write_data  out  32; write_enable  out  1. Both drive the Pins block write port.
REQ-011 SHALL have ports: stall  out  1 (requested op not completed this cycle); osr_count  out  6 (bits consumed, 0..32).

Function
REQ-012 SHALL hold a 32-bit OSR plus a shift counter cnt (0..32); osr_count SHALL equal cnt.
REQ-013 OUT, right shift: SHALL extract OSR[n-1:0] right-justified and set OSR <= OSR >> n.
REQ-014 OUT, left shift: SHALL extract OSR[31:32-n] right-justified and set OSR <= OSR << n.
REQ-015 OUT SHALL update cnt <= min(cnt+n, 32); n = 32 SHALL empty the OSR fully, with no shift-by-width hazard.
REQ-016 OUT SHALL register the extracted value onto write_data and pulse write_enable high for exactly 1 cycle, the cycle after acceptance (latency 1).
REQ-017 write_data SHALL hold its last value while write_enable is low.
REQ-018 Refill SHALL mean: fifo_ready high combinationally for that cycle only when fifo_valid=1; OSR <= fifo_data; cnt <= 0.
REQ-019 Autopull SHALL refill when cfg_autopull=1, cnt >= thresh and fifo_valid=1, independent of op inputs.
REQ-020 With autopull, an OUT SHALL stall (stall=1, no shift, no write) while cnt >= thresh. This applies both in the refill cycle and while fifo_valid=0. The OUT SHALL execute in the first cycle after cnt < thresh.
REQ-021 Blocking PULL (op_block=1) SHALL refill if fifo_valid=1 and SHALL otherwise stall with OSR unchanged until fifo_valid=1.
REQ-022 Non-blocking PULL with fifo_valid=0 SHALL load OSR <= 0 and cnt <= 0 without stalling.
REQ-023 PULL SHALL never produce write_enable.
REQ-024 stall SHALL be combinational; the sequencer SHALL hold op inputs stable while stall=1.
REQ-025 If op_out and op_pull are both asserted, op_pull SHALL take effect and op_out SHALL be ignored, with stall=0 for the ignored op.
REQ-026 A PULL and an autopull SHALL never pop twice in one cycle: at most one fifo_ready pulse per cycle.
REQ-027 fifo_ready SHALL never be high while fifo_valid=0.

Reset
REQ-028 While reset_n=0, the block SHALL force OSR=0, cnt=32, write_data=0 and write_enable=0 asynchronously. fifo_ready and stall SHALL read 0 during reset.
REQ-029 A reset asserted mid-operation SHALL discard any pending write_enable and any stalled op; no pop SHALL occur in the reset cycle.
REQ-030 After reset release, the first refill SHALL follow REQ-019 or REQ-021.

Structure
REQ-031 Shift-direction constants (SHIFT_LEFT=0, SHIFT_RIGHT=1) and DATA_WIDTH SHALL reside in shared package pio_pkg.
REQ-032 Bit extraction and shifting SHALL be one combinational sub-module, osr_extract (inputs: osr, n, dir; outputs: data, next_osr).

Verification
REQ-033 Reset: pulse reset_n low, then release -> write_enable=0, fifo_ready=0, stall=0, osr_count=32, write_data=0.
REQ-034 Right OUT: blocking PULL of 0xA5A500FF, then OUT 8, OUT 8 -> write_data 0x000000FF, then 0x00000000, each with a 1-cycle write_enable; osr_count 8, then 16.
REQ-035 Left OUT: PULL of 0xF0000001, then OUT 4, OUT 28 -> write_data 0x0000000F, then 0x00000001; osr_count 32.
REQ-036 Autopull with thresh=16 and right shift:
  - FIFO holds 0x12345678 -> refill occurs; OUT 16 -> write_data 0x00005678.
  - Then with 0xCAFEBABE valid, OUT 16 -> stall for 1 cycle with a fifo_ready pulse, then write_data 0x0000BABE.
REQ-037 Blocking PULL, FIFO empty for 3 cycles -> stall=1 for 3 cycles. fifo_valid then rises with 0xDEADBEEF -> fifo_ready and stall=0 in the same cycle; osr_count=0.
REQ-038 Non-blocking PULL, FIFO empty -> no stall, OSR=0, osr_count=0.
REQ-039 Mid-operation reset: reset_n low in the cycle after an accepted OUT -> write_enable drops immediately and osr_count=32.
